// File: rtl/axis_fifo_lvl_pkg.sv
// axis_fifo_lvl_pkg: shared sizing helpers and payload field layout for the
// level-reporting AXI4-Stream FIFO. The stored word is packed as
// {tdata, tkeep, tlast, tuser} with tuser in the least significant bits.
// Optional feature macro used by this block: AXIS_FIFO_LVL_PEAK_EN.
package axis_fifo_lvl_pkg;

    // tuser always sits at the bottom of the stored word
    localparam int USER_OFF = 0;

    // Address width of a DEPTH-entry memory (DEPTH is a power of two)
    function automatic int calc_addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // tlast sits directly above tuser
    function automatic int calc_last_off(input int user_w);
        return USER_OFF + user_w;
    endfunction

    // tkeep sits directly above tlast
    function automatic int calc_keep_off(input int user_w);
        return USER_OFF + user_w + 1;
    endfunction

    // tdata occupies the top of the word
    function automatic int calc_data_off(input int keep_w, input int user_w);
        return USER_OFF + user_w + 1 + keep_w;
    endfunction

    // Total stored word width
    function automatic int calc_payload_w(input int data_w, input int keep_w, input int user_w);
        return data_w + keep_w + user_w + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_lvl_if.sv
// axis_fifo_lvl_if: one AXI4-Stream channel. The producer uses the master
// modport, the consumer the slave modport.
interface axis_fifo_lvl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/axis_fifo_lvl_ram.sv
// axis_fifo_lvl_ram: simple dual-port storage array, synchronous write and
// asynchronous read. Kept separate so a vendor RAM macro can replace it.
module axis_fifo_lvl_ram
    import axis_fifo_lvl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 11,
    localparam int AW = calc_addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store the incoming word on the clock edge
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_fifo_lvl.sv
// axis_fifo_lvl: single-clock AXI4-Stream FIFO with a DEPTH-entry memory plus
// one output register (DEPTH+1 words total), fill-level reporting,
// programmable almost-full/almost-empty watermarks and a one-cycle flush.
// Optional macro AXIS_FIFO_LVL_PEAK_EN adds a resettable high-water mark.
module axis_fifo_lvl
    import axis_fifo_lvl_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    localparam int ADDR_WIDTH = calc_addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_fifo_lvl_if.slave        s_axis,
    axis_fifo_lvl_if.master       m_axis,
    input  logic                  flush,
    input  logic [ADDR_WIDTH:0]   afull_thresh,
    input  logic [ADDR_WIDTH:0]   aempty_thresh,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  status_full,
    output logic                  status_empty,
    output logic                  status_almost_full,
    output logic                  status_almost_empty
`ifdef AXIS_FIFO_LVL_PEAK_EN
    ,
    input  logic                  peak_clr,
    output logic [ADDR_WIDTH:0]   peak_level
`endif
);

    localparam int LAST_OFF  = calc_last_off(USER_WIDTH);
    localparam int KEEP_OFF  = calc_keep_off(USER_WIDTH);
    localparam int DATA_OFF  = calc_data_off(KEEP_WIDTH, USER_WIDTH);
    localparam int PAYLOAD_W = calc_payload_w(DATA_WIDTH, KEEP_WIDTH, USER_WIDTH);

    localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] LEVEL_MAX = (ADDR_WIDTH+1)'(DEPTH + 1);

    logic [ADDR_WIDTH:0]  wr_ptr;
    logic [ADDR_WIDTH:0]  rd_ptr;
    logic [ADDR_WIDTH:0]  level_r;
    logic [ADDR_WIDTH:0]  level_next;
    logic                 mem_full;
    logic                 mem_empty;
    logic                 s_ready;
    logic                 wr_en;
    logic                 out_valid;
    logic                 out_load;
    logic                 rd_en;
    logic                 out_hs;
    logic [PAYLOAD_W-1:0] wr_word;
    logic [PAYLOAD_W-1:0] rd_word;
    logic [PAYLOAD_W-1:0] out_word;

    assign mem_empty = (wr_ptr == rd_ptr);
    assign mem_full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                       (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    // Ready depends only on registered state and flush, never on tvalid
    assign s_ready       = !mem_full && !flush;
    assign s_axis.tready = s_ready;
    assign wr_en         = s_axis.tvalid && s_ready;

    // Output register refills whenever it is empty or being consumed
    assign out_load = !out_valid || m_axis.tready;
    assign rd_en    = out_load && !mem_empty && !flush;
    assign out_hs   = out_valid && m_axis.tready;

    assign wr_word = {s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tuser};

    axis_fifo_lvl_ram #(
        .DEPTH (DEPTH),
        .WIDTH (PAYLOAD_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_word),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (rd_word)
    );

    // Pointer update: flush and reset both return the memory to empty
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ONE;
            end
        end
    end

    // Output valid flag: a held word is dropped on flush
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid <= 1'b0;
        end else if (out_load) begin
            out_valid <= !mem_empty;
        end
    end

    // Output payload: loads only when a new word moves out of memory
    always_ff @(posedge clk) begin
        if (rd_en) begin
            out_word <= rd_word;
        end
    end

    // Next fill level: input handshake adds, output handshake subtracts
    always_comb begin
        level_next = level_r;
        if (flush) begin
            level_next = '0;
        end else if (wr_en && !out_hs) begin
            level_next = level_r + ONE;
        end else if (!wr_en && out_hs) begin
            level_next = level_r - ONE;
        end
    end

    // Fill level register
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r <= '0;
        end else begin
            level_r <= level_next;
        end
    end

`ifdef AXIS_FIFO_LVL_PEAK_EN
    logic [ADDR_WIDTH:0] peak_r;

    // High-water mark: survives flush, restarts from the current level on clear
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_r <= '0;
        end else if (peak_clr) begin
            peak_r <= level_next;
        end else if (level_next > peak_r) begin
            peak_r <= level_next;
        end
    end

    assign peak_level = peak_r;
`endif

    assign m_axis.tvalid = out_valid;
    assign m_axis.tuser  = out_word[USER_OFF +: USER_WIDTH];
    assign m_axis.tlast  = out_word[LAST_OFF];
    assign m_axis.tkeep  = out_word[KEEP_OFF +: KEEP_WIDTH];
    assign m_axis.tdata  = out_word[DATA_OFF +: DATA_WIDTH];

    assign level               = level_r;
    assign status_full         = (level_r == LEVEL_MAX);
    assign status_empty        = (level_r == '0);
    assign status_almost_full  = (level_r >= afull_thresh);
    assign status_almost_empty = (level_r <= aempty_thresh);

endmodule
